// File: rtl/fix_msg_request_queue.sv
// Request FIFO between session_manager and create_message: issues one request at a time,
// coalesces duplicate heartbeats per host, and abandons a message whose done never arrives.
`ifndef NUMBER_OF_HOST
`define NUMBER_OF_HOST 4
`endif
`ifndef VALUE_DATA_WIDTH
`define VALUE_DATA_WIDTH 8
`endif
`ifndef LOGON
`define LOGON 4'd1
`endif
`ifndef LOGOUT
`define LOGOUT 4'd2
`endif
`ifndef HEARTBEAT
`define HEARTBEAT 4'd3
`endif
`ifndef resendReq
`define resendReq 4'd4
`endif

module fix_msg_request_queue #(
  parameter int NUM_HOST     = `NUMBER_OF_HOST,
  parameter int VALUE_WIDTH  = `VALUE_DATA_WIDTH,
  parameter int DEPTH        = 4,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       initiate_msg_i,
  input  logic [3:0]                 create_message_i,
  input  logic [VALUE_WIDTH-1:0]     targetCompId_i,
  input  logic [NUM_HOST-1:0]        host_i,
  input  logic                       cm_busy_i,
  input  logic                       cm_done_i,
  output logic                       cm_start_o,
  output logic [3:0]                 cm_type_o,
  output logic [VALUE_WIDTH-1:0]     cm_targetCompId_o,
  output logic [NUM_HOST-1:0]        cm_host_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       drop_o,
  output logic                       coalesce_o,
  output logic                       cm_timeout_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DONE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [3:0] TYPE_HB = `HEARTBEAT;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

  typedef struct packed {
    logic [3:0]             msg_type;
    logic [VALUE_WIDTH-1:0] compid;
    logic [NUM_HOST-1:0]    host;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             req, cm_entry_d, cm_entry_q;
  state_e             state_d, state_q;
  logic [TMR_W-1:0]   timer_d, timer_q;
  logic [PTR_W-1:0]   rd_ptr_d, rd_ptr_q, wr_ptr_d, wr_ptr_q;
  logic [CNT_W-1:0]   count_d, count_q;
  logic               start_d, start_q, timeout_d, timeout_q;
  logic               drop_d, drop_q, coalesce_d, coalesce_q;
  logic               empty_d, empty_q, full_d, full_q;
  logic               push, pop, hb_hit;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    cm_entry_d = cm_entry_q;
    start_d    = 1'b0;
    timeout_d  = 1'b0;
    drop_d     = 1'b0;
    coalesce_d = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    hb_hit     = 1'b0;
    req        = '{msg_type: create_message_i, compid: targetCompId_i, host: host_i};

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0 && !cm_busy_i) begin
          pop        = 1'b1;
          start_d    = 1'b1;
          cm_entry_d = mem_q[rd_ptr_q];
          timer_d    = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cm_done_i) begin
          state_d = ST_IDLE;
        end else if (timer_q == TMR_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
    endcase

    // Search only live entries; the head leaving this cycle no longer counts as queued.
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q && !(pop && i == 0) &&
          mem_q[rd_ptr_q + PTR_W'(i)].msg_type == TYPE_HB &&
          mem_q[rd_ptr_q + PTR_W'(i)].host == host_i)
        hb_hit = 1'b1;
    end

    if (initiate_msg_i && create_message_i != 4'd0) begin
      if (create_message_i == TYPE_HB && hb_hit) coalesce_d = 1'b1;
      else if (count_q == CNT_FULL && !pop)      drop_d     = 1'b1;
      else                                       push       = 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);
  end

  // NOTE: the storage array has no reset; only entries inside the count window are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      cm_entry_q <= '0;
      start_q    <= 1'b0;
      timeout_q  <= 1'b0;
      drop_q     <= 1'b0;
      coalesce_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      cm_entry_q <= cm_entry_d;
      start_q    <= start_d;
      timeout_q  <= timeout_d;
      drop_q     <= drop_d;
      coalesce_q <= coalesce_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
    end
  end

  assign cm_start_o        = start_q;
  assign cm_type_o         = cm_entry_q.msg_type;
  assign cm_targetCompId_o = cm_entry_q.compid;
  assign cm_host_o         = cm_entry_q.host;
  assign count_o           = count_q;
  assign empty_o           = empty_q;
  assign full_o            = full_q;
  assign drop_o            = drop_q;
  assign coalesce_o        = coalesce_q;
  assign cm_timeout_o      = timeout_q;
endmodule

// File: tb/tb_fix_msg_request_queue.sv
// Directed bench for fix_msg_request_queue (DEPTH=4, DONE_TIMEOUT=8): issue order, overflow,
// heartbeat coalescing, push-while-popping when full, done watchdog, and mid-flight reset.
`ifndef NUMBER_OF_HOST
`define NUMBER_OF_HOST 4
`endif
`ifndef VALUE_DATA_WIDTH
`define VALUE_DATA_WIDTH 8
`endif
`ifndef LOGON
`define LOGON 4'd1
`endif
`ifndef LOGOUT
`define LOGOUT 4'd2
`endif
`ifndef HEARTBEAT
`define HEARTBEAT 4'd3
`endif
`ifndef resendReq
`define resendReq 4'd4
`endif

module tb_fix_msg_request_queue;
  localparam int NH = `NUMBER_OF_HOST;
  localparam int VW = `VALUE_DATA_WIDTH;

  logic          clk, rst;
  logic          init, busy, done;
  logic [3:0]    typ;
  logic [VW-1:0] cid;
  logic [NH-1:0] host;
  logic          start_o, empty_o, full_o, drop_o, coal_o, tmo_o;
  logic [3:0]    type_o;
  logic [VW-1:0] cid_o;
  logic [NH-1:0] host_o;
  logic [2:0]    count_o;

  int vectors = 0;
  int errors  = 0;

  fix_msg_request_queue #(.DEPTH(4), .DONE_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .initiate_msg_i(init), .create_message_i(typ), .targetCompId_i(cid), .host_i(host),
    .cm_busy_i(busy), .cm_done_i(done),
    .cm_start_o(start_o), .cm_type_o(type_o), .cm_targetCompId_o(cid_o), .cm_host_o(host_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
    .drop_o(drop_o), .coalesce_o(coal_o), .cm_timeout_o(tmo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] t, input logic [VW-1:0] c, input logic [NH-1:0] h);
    init = 1'b1; typ = t; cid = c; host = h;
    tick();
    init = 1'b0;
  endtask

  task automatic finish_msg();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic expect_issue(input string tag, input logic [3:0] t, input logic [VW-1:0] c,
                              input logic [NH-1:0] h);
    tick();
    chk({tag, "_start"}, 32'(start_o), 1);
    chk({tag, "_type"},  32'(type_o),  32'(t));
    chk({tag, "_cid"},   32'(cid_o),   32'(c));
    chk({tag, "_host"},  32'(host_o),  32'(h));
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; typ = '0; cid = '0; host = '0; busy = 1'b0; done = 1'b0;
    #1;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_full",  32'(full_o),  0);
    chk("rst_start", 32'(start_o), 0);
    tick(); tick();
    rst = 1'b0;

    // 1: single request, start one cycle after the push is visible
    push(`LOGON, 8'h55, 2);
    chk("t1_count1", 32'(count_o), 1);
    chk("t1_nostart", 32'(start_o), 0);
    expect_issue("t1", `LOGON, 8'h55, 2);
    chk("t1_count0", 32'(count_o), 0);
    tick();
    chk("t1_pulse_end", 32'(start_o), 0);
    finish_msg();
    chk("t1_type_hold", 32'(type_o), 32'(`LOGON));

    // 2: overflow while busy, then FIFO-order drain
    busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(`LOGON, 8'(8'h10 + i), 0);
      chk("t2_count", 32'(count_o), (i < 4) ? i + 1 : 4);
      if (i == 3) chk("t2_full", 32'(full_o), 1);
      chk("t2_drop", 32'(drop_o), (i == 4) ? 1 : 0);
    end
    tick();
    chk("t2_drop_end", 32'(drop_o), 0);
    busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_issue("t2", `LOGON, 8'(8'h10 + i), 0);
      finish_msg();
    end
    chk("t2_empty", 32'(empty_o), 1);

    // 3: heartbeat coalescing
    busy = 1'b1;
    push(`HEARTBEAT, 8'h00, 1);
    chk("t3_coal_a", 32'(coal_o), 0);
    push(`HEARTBEAT, 8'h00, 1);
    chk("t3_coal_b", 32'(coal_o), 1);
    chk("t3_count_b", 32'(count_o), 1);
    push(`HEARTBEAT, 8'h00, 3);
    chk("t3_coal_c", 32'(coal_o), 0);
    chk("t3_count_c", 32'(count_o), 2);
    push(4'd0, 8'h77, 3);
    chk("t3_type0_count", 32'(count_o), 2);
    chk("t3_type0_coal", 32'(coal_o), 0);
    busy = 1'b0;
    expect_issue("t3a", `HEARTBEAT, 8'h00, 1);
    finish_msg();
    expect_issue("t3b", `HEARTBEAT, 8'h00, 3);
    // in-flight heartbeat is not a coalesce target
    push(`HEARTBEAT, 8'h00, 3);
    chk("t3_inflight_coal", 32'(coal_o), 0);
    chk("t3_inflight_count", 32'(count_o), 1);
    finish_msg();
    expect_issue("t3c", `HEARTBEAT, 8'h00, 3);
    finish_msg();

    // 4: push on the issuing edge while full
    busy = 1'b1;
    for (int i = 0; i < 4; i++) push(`resendReq, 8'(8'h20 + i), 1);
    chk("t4_full", 32'(full_o), 1);
    busy = 1'b0;
    push(`LOGOUT, 8'h24, 2);
    chk("t4_drop", 32'(drop_o), 0);
    chk("t4_count", 32'(count_o), 4);
    chk("t4_start", 32'(start_o), 1);
    chk("t4_cid0", 32'(cid_o), 32'h20);
    for (int i = 1; i < 4; i++) begin
      finish_msg();
      expect_issue("t4", `resendReq, 8'(8'h20 + i), 1);
    end
    finish_msg();
    expect_issue("t4_last", `LOGOUT, 8'h24, 2);
    finish_msg();

    // 5: done watchdog (DONE_TIMEOUT=8)
    busy = 1'b1;
    push(`LOGOUT, 8'h30, 1);
    push(`resendReq, 8'h31, 2);
    busy = 1'b0;
    expect_issue("t5a", `LOGOUT, 8'h30, 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t5_no_timeout", 32'(tmo_o), 0);
    end
    chk("t5_type_hold", 32'(type_o), 32'(`LOGOUT));
    tick();
    chk("t5_timeout", 32'(tmo_o), 1);
    chk("t5_no_start", 32'(start_o), 0);
    expect_issue("t5b", `resendReq, 8'h31, 2);
    chk("t5_timeout_end", 32'(tmo_o), 0);
    finish_msg();

    // 6: reset in WAIT with three entries queued
    busy = 1'b1;
    for (int i = 0; i < 4; i++) push(`LOGON, 8'(8'h40 + i), 0);
    busy = 1'b0;
    expect_issue("t6", `LOGON, 8'h40, 0);
    chk("t6_count3", 32'(count_o), 3);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_start", 32'(start_o), 0);
    chk("t6_rst_count", 32'(count_o), 0);
    chk("t6_rst_empty", 32'(empty_o), 1);
    chk("t6_rst_type",  32'(type_o),  0);
    chk("t6_rst_cid",   32'(cid_o),   0);
    chk("t6_rst_host",  32'(host_o),  0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_post_start", 32'(start_o), 0);
      chk("t6_post_count", 32'(count_o), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
